// File: rtl/nn_inference_sequencer.sv
// Sequencer for one inference pass: input fill, ordered layer req/ack with a per-layer watchdog, output drain.
// Optional `NN_SEQ_PERF_EN adds the perf_cycles pass-length counter port.
module nn_inference_sequencer #(
  parameter int NUM_LAYERS = 2,
  parameter int IN_DEPTH   = 2,
  parameter int OUT_DEPTH  = 1,
  parameter int DATA_W     = 8,
  parameter int TIMEOUT    = 255,
  localparam int IAW = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1,
  localparam int OAW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1,
  localparam int WW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic                  buf_we,
  output logic [IAW-1:0]        buf_addr,
  output logic [DATA_W-1:0]     buf_wdata,
  output logic [NUM_LAYERS-1:0] layer_req,
  input  logic [NUM_LAYERS-1:0] layer_ack,
  output logic [OAW-1:0]        res_addr,
  input  logic [DATA_W-1:0]     res_data,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [2:0]            layer_idx
`ifdef NN_SEQ_PERF_EN
  ,
  output logic [31:0]           perf_cycles
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_WAIT, S_DRAIN, S_ERR} state_t;

  localparam logic [IAW-1:0] LAST_FILL  = IAW'(IN_DEPTH - 1);
  localparam logic [OAW-1:0] LAST_OUT   = OAW'(OUT_DEPTH - 1);
  localparam logic [2:0]     LAST_LAYER = 3'(NUM_LAYERS - 1);
  localparam logic [WW-1:0]  WAIT_MAX   = WW'(TIMEOUT);

  state_t                state_reg, state_next;
  logic [IAW-1:0]        fill_idx_reg;
  logic [WW-1:0]         wcnt_reg;
  logic [2:0]            layer_idx_reg;
  logic [OAW-1:0]        res_addr_reg;
  logic                  buf_we_reg, out_valid_reg, done_reg, error_reg;
  logic [IAW-1:0]        buf_addr_reg;
  logic [DATA_W-1:0]     buf_wdata_reg, out_data_reg;
  logic [NUM_LAYERS-1:0] ack_hit;
  logic                  ack_cur, req_on;

  assign req_on  = (state_reg == S_RUN) || (state_reg == S_WAIT) || (state_reg == S_DRAIN);
  assign ack_cur = |ack_hit;

  // Requests are cumulative up to the running layer; only the running layer's ack matters.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
      assign layer_req[gi] = req_on && (3'(gi) <= layer_idx_reg);
      assign ack_hit[gi]   = layer_ack[gi] && (3'(gi) == layer_idx_reg);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (start) state_next = S_FILL;
      S_FILL:  if (in_valid && (fill_idx_reg == LAST_FILL)) state_next = S_RUN;
      S_RUN:   state_next = S_WAIT;
      S_WAIT: begin
        if (ack_cur)                    state_next = (layer_idx_reg == LAST_LAYER) ? S_DRAIN : S_RUN;
        else if (wcnt_reg == WAIT_MAX)  state_next = S_ERR;
      end
      S_DRAIN: if (out_valid_reg && out_ready && (res_addr_reg == LAST_OUT)) state_next = S_IDLE;
      S_ERR:   if (start) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_idx_reg  <= '0;
      wcnt_reg      <= '0;
      layer_idx_reg <= '0;
      res_addr_reg  <= '0;
      buf_we_reg    <= 1'b0;
      buf_addr_reg  <= '0;
      buf_wdata_reg <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      done_reg      <= 1'b0;
      error_reg     <= 1'b0;
    end else begin
      buf_we_reg <= 1'b0;
      done_reg   <= 1'b0;
      case (state_reg)
        S_IDLE: if (start) begin
          fill_idx_reg  <= '0;
          wcnt_reg      <= '0;
          layer_idx_reg <= '0;
          res_addr_reg  <= '0;
          error_reg     <= 1'b0;
        end
        S_FILL: if (in_valid) begin
          buf_we_reg    <= 1'b1;
          buf_addr_reg  <= fill_idx_reg;
          buf_wdata_reg <= in_data;
          fill_idx_reg  <= (fill_idx_reg == LAST_FILL) ? '0 : fill_idx_reg + IAW'(1);
        end
        S_RUN: wcnt_reg <= '0;
        S_WAIT: begin
          if (ack_cur) begin
            if (layer_idx_reg != LAST_LAYER) begin
              layer_idx_reg <= layer_idx_reg + 3'd1;
            end else begin
              // res_addr is still 0 here, so res_data already holds the first result.
              res_addr_reg  <= '0;
              out_data_reg  <= res_data;
              out_valid_reg <= 1'b1;
            end
          end else if (wcnt_reg == WAIT_MAX) begin
            error_reg <= 1'b1;
          end else begin
            wcnt_reg <= wcnt_reg + WW'(1);
          end
        end
        S_DRAIN: begin
          if (!out_valid_reg) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= res_data;
          end else if (out_ready) begin
            out_valid_reg <= 1'b0;
            if (res_addr_reg == LAST_OUT) done_reg <= 1'b1;
            else                          res_addr_reg <= res_addr_reg + OAW'(1);
          end
        end
        S_ERR: if (start) error_reg <= 1'b0;
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_reg == S_FILL);
  assign busy      = (state_reg != S_IDLE);
  assign buf_we    = buf_we_reg;
  assign buf_addr  = buf_addr_reg;
  assign buf_wdata = buf_wdata_reg;
  assign res_addr  = res_addr_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign done      = done_reg;
  assign error     = error_reg;
  assign layer_idx = layer_idx_reg;

`ifdef NN_SEQ_PERF_EN
  logic [31:0] perf_reg;

  // Frozen in ERR and held in IDLE until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          perf_reg <= '0;
    else if ((state_reg == S_IDLE) && start)          perf_reg <= '0;
    else if ((state_reg != S_IDLE) && (state_reg != S_ERR)) perf_reg <= perf_reg + 32'd1;
  end

  assign perf_cycles = perf_reg;
`endif

endmodule
